// File: rtl/mpc_bank_arbiter_if.sv
// mpc_bank_arbiter_if: channel request bundle and bank request bundle for one bank arbiter
interface mpc_bank_arbiter_if #(
   parameter int N_CH   = 3,
   parameter int WBUF_W = 5
);
   logic [N_CH-1:0]                   ch_valid_i;
   logic [N_CH-1:0]                   ch_ready_o;
   logic [3*N_CH-1:0]                 ch_op_i;
   logic [32*N_CH-1:0]                ch_addr_i;
   logic [128*N_CH-1:0]               ch_wdata_i;
   logic [WBUF_W*N_CH-1:0]            ch_wbuf_id_i;
   logic                              bank_valid_o;
   logic                              bank_ready_i;
   logic [N_CH+WBUF_W+3+32+128-1:0]   bank_req_o;
   logic                              err_illegal_op_o;

   modport slave (
      input  ch_valid_i, ch_op_i, ch_addr_i, ch_wdata_i, ch_wbuf_id_i, bank_ready_i,
      output ch_ready_o, bank_valid_o, bank_req_o, err_illegal_op_o
   );

   modport master (
      output ch_valid_i, ch_op_i, ch_addr_i, ch_wdata_i, ch_wbuf_id_i, bank_ready_i,
      input  ch_ready_o, bank_valid_o, bank_req_o, err_illegal_op_o
   );
endinterface

// File: rtl/mpc_bank_arbiter.sv
// mpc_bank_arbiter: round-robin arbiter granting one bank-matching channel request per cycle into a single output register
module mpc_bank_arbiter #(
   parameter int N_CH       = 3,
   parameter int BANK_ID    = 0,
   parameter int BANK_WIDTH = 2,
   parameter int BANK_LSB   = 6,
   parameter int WBUF_W     = 5
) (
   input logic              clk_i,
   input logic              rst_ni,
   mpc_bank_arbiter_if.slave bus
);
   localparam int PTR_W = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int REQ_W = N_CH + WBUF_W + 3 + 32 + 128;

   logic [N_CH-1:0]   match, gnt_oh;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d, nxt_ptr;
   logic              found, ld, gnt, legal;
   logic [2:0]        sel_op;
   logic [31:0]       sel_addr;
   logic [127:0]      sel_wdata;
   logic [WBUF_W-1:0] sel_wbuf;
   logic              bank_valid_q, bank_valid_d, err_q, err_d;
   logic [REQ_W-1:0]  bank_req_q, bank_req_d;

   // bank match per channel, then first match scanning upward from the round-robin pointer
   always_comb begin
      match   = '0;
      gnt_oh  = '0;
      nxt_ptr = '0;
      found   = 1'b0;
      for (int k = 0; k < N_CH; k++)
         match[k] = bus.ch_valid_i[k] &
                    (bus.ch_addr_i[32*k+BANK_LSB +: BANK_WIDTH] == BANK_WIDTH'(BANK_ID));
      for (int i = 0; i < N_CH; i++) begin
         int j;
         j = (int'(rr_ptr_q) + i) % N_CH;
         if (!found && match[j]) begin
            found   = 1'b1;
            gnt_oh  = N_CH'(1) << j;
            nxt_ptr = PTR_W'((j + 1) % N_CH);
         end
      end
   end

   // mux out the granted channel's request fields
   always_comb begin
      sel_op    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wbuf  = '0;
      for (int k = 0; k < N_CH; k++)
         if (gnt_oh[k]) begin
            sel_op    = bus.ch_op_i[3*k +: 3];
            sel_addr  = bus.ch_addr_i[32*k +: 32];
            sel_wdata = bus.ch_wdata_i[128*k +: 128];
            sel_wbuf  = bus.ch_wbuf_id_i[WBUF_W*k +: WBUF_W];
         end
   end

   // a grant needs a free (or draining) output register and is suppressed while in reset
   assign ld             = !bank_valid_q | bus.bank_ready_i;
   assign gnt            = ld & found & rst_ni;
   assign legal          = sel_op <= 3'd1;
   assign bus.ch_ready_o = gnt ? gnt_oh : '0;

   // next output register contents; illegal ops are consumed but only raise the error pulse
   always_comb begin
      bank_valid_d = ld ? (gnt & legal) : bank_valid_q;
      bank_req_d   = (gnt & legal) ?
                     {gnt_oh, {WBUF_W{sel_op == 3'd1}} & sel_wbuf, sel_op, sel_addr, sel_wdata} :
                     bank_req_q;
      err_d        = gnt & !legal;
      rr_ptr_d     = gnt ? nxt_ptr : rr_ptr_q;
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bank_valid_q <= 1'b0;
         bank_req_q   <= '0;
         err_q        <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         bank_valid_q <= bank_valid_d;
         bank_req_q   <= bank_req_d;
         err_q        <= err_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign bus.bank_valid_o     = bank_valid_q;
   assign bus.bank_req_o       = bank_req_q;
   assign bus.err_illegal_op_o = err_q;
endmodule

// File: tb/tb_mpc_bank_arbiter.sv
// tb_mpc_bank_arbiter: vector table plus bank-side scoreboard for the bank arbiter
module tb_mpc_bank_arbiter;
   typedef logic [170:0] req_t;
   typedef struct {
      logic [2:0]  valid;
      logic [8:0]  op;
      logic [95:0] addr;
      logic        br;
      logic [2:0]  er;
      logic        ebv;
      logic        eerr;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   int          n_chk = 0;
   int          n_fail = 0;
   req_t        sb[$];
   vec_t        vecs[$];
   logic [14:0] wbuf_all = {5'd7, 5'd5, 5'd3};
   logic [8:0]  ops_std  = {3'd0, 3'd1, 3'd0};
   logic [8:0]  ops_ill  = {3'd0, 3'd1, 3'd4};
   logic [95:0] a_std    = {32'h200, 32'h100, 32'h0};
   logic [95:0] a_flt    = {32'h40, 32'h100, 32'h80};

   mpc_bank_arbiter_if #(.N_CH(3), .WBUF_W(5)) bus ();

   mpc_bank_arbiter dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(logic [2:0] valid, logic [8:0] op, logic [95:0] addr, logic br,
                               logic [2:0] er, logic ebv, logic eerr);
      vec_t v;
      v.valid = valid; v.op = op; v.addr = addr; v.br = br;
      v.er = er; v.ebv = ebv; v.eerr = eerr;
      return v;
   endfunction

   function automatic logic [127:0] wd(int k, logic [31:0] a);
      return {4{32'hA5A5_A5A5 ^ a ^ 32'(k)}};
   endfunction

   function automatic req_t exp_req(vec_t v);
      req_t r = '0;
      for (int k = 0; k < 3; k++)
         if (v.er[k]) begin
            logic [2:0] op;
            op = v.op[3*k +: 3];
            r = {v.er, (op == 3'd1) ? wbuf_all[5*k +: 5] : 5'd0, op, v.addr[32*k +: 32],
                 wd(k, v.addr[32*k +: 32])};
         end
      return r;
   endfunction

   task automatic chk(string name, req_t act, req_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.ch_valid_i   = v.valid;
      bus.ch_op_i      = v.op;
      bus.ch_addr_i    = v.addr;
      bus.ch_wbuf_id_i = wbuf_all;
      bus.bank_ready_i = v.br;
      for (int k = 0; k < 3; k++) bus.ch_wdata_i[128*k +: 128] = wd(k, v.addr[32*k +: 32]);
   endtask

   task automatic cycle(vec_t v);
      @(negedge clk_i);
      drive(v);
      #1;
      chk("ch_ready", req_t'(bus.ch_ready_o), req_t'(v.er));
      chk("bank_valid", req_t'(bus.bank_valid_o), req_t'(v.ebv));
      chk("err_illegal_op", req_t'(bus.err_illegal_op_o), req_t'(v.eerr));
      if (bus.bank_valid_o) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL bank_req_unexpected: got %h with empty scoreboard", bus.bank_req_o);
         end else begin
            chk("bank_req", bus.bank_req_o, sb[0]);
            if (v.br) void'(sb.pop_front());
         end
      end
      if (v.er != 3'b000) begin
         logic [2:0] op = 3'd0;
         for (int k = 0; k < 3; k++) if (v.er[k]) op = v.op[3*k +: 3];
         if (op <= 3'd1) sb.push_back(exp_req(v));
      end
   endtask

   initial begin
      // contention from pointer 0, then drain
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));
      vecs.push_back(mk(3'b111, ops_std, a_std, 1, 3'b001, 0, 0));
      vecs.push_back(mk(3'b111, ops_std, a_std, 1, 3'b010, 1, 0));
      vecs.push_back(mk(3'b111, ops_std, a_std, 1, 3'b100, 1, 0));
      vecs.push_back(mk(3'b111, ops_std, a_std, 1, 3'b001, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));
      // single ch0 load with pointer at 1
      vecs.push_back(mk(3'b001, ops_std, a_std, 1, 3'b001, 0, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));
      // ch1 store then 4 cycles of backpressure with ch2 waiting
      vecs.push_back(mk(3'b010, ops_std, a_std, 1, 3'b010, 0, 0));
      repeat (4) vecs.push_back(mk(3'b100, ops_std, a_std, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b100, ops_std, a_std, 1, 3'b100, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));
      // other-bank addresses are never accepted
      repeat (3) vecs.push_back(mk(3'b101, ops_std, a_flt, 1, 3'b000, 0, 0));
      // illegal op on ch0: consumed, error pulse, pointer moves to 1
      vecs.push_back(mk(3'b001, ops_ill, a_std, 1, 3'b001, 0, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 1));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));
      vecs.push_back(mk(3'b101, ops_std, a_std, 1, 3'b100, 0, 0));
      vecs.push_back(mk(3'b001, ops_std, a_std, 1, 3'b001, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));

      // initial reset with a matching request present
      rst_ni = 1'b0;
      drive(mk(3'b001, ops_std, a_std, 1, 3'b000, 0, 0));
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_ch_ready", req_t'(bus.ch_ready_o), '0);
      chk("rst_bank_valid", req_t'(bus.bank_valid_o), '0);
      chk("rst_bank_req", bus.bank_req_o, '0);
      chk("rst_err", req_t'(bus.err_illegal_op_o), '0);
      bus.ch_valid_i = 3'b000;
      rst_ni = 1'b1;

      for (int i = 0; i < vecs.size(); i++) cycle(vecs[i]);

      // reset while a request is stalled, pointer at 2 before the reset
      cycle(mk(3'b010, ops_std, a_std, 1, 3'b010, 0, 0));
      cycle(mk(3'b000, ops_std, a_std, 0, 3'b000, 1, 0));
      @(negedge clk_i);
      bus.ch_valid_i = 3'b110;
      rst_ni = 1'b0;
      #1;
      chk("midrst_bank_valid", req_t'(bus.bank_valid_o), '0);
      chk("midrst_bank_req", bus.bank_req_o, '0);
      chk("midrst_ch_ready", req_t'(bus.ch_ready_o), '0);
      sb.delete();
      @(negedge clk_i);
      #1;
      chk("midrst_ch_ready_held", req_t'(bus.ch_ready_o), '0);
      bus.ch_valid_i = 3'b000;
      rst_ni = 1'b1;
      cycle(mk(3'b110, ops_std, a_std, 1, 3'b010, 0, 0));
      cycle(mk(3'b000, ops_std, a_std, 1, 3'b000, 1, 0));
      cycle(mk(3'b000, ops_std, a_std, 1, 3'b000, 0, 0));

      chk("scoreboard_drained", req_t'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mpc_bank_arbiter.md
Name: mpc_bank_arbiter

Overview:
Per-bank request arbiter for the multi-port cache. It collects channel requests whose address maps to this bank and grants one per cycle under round-robin priority. The granted request is packed into a bank request (one-hot channel id, write-buffer id, op, addr, wdata) in a single output register stage that feeds the bank pipeline. One instance per bank sits between the channel front-ends and the bank tag/data pipeline.

Parameters:
N_CH, 3, number of requesting channels; width of the one-hot channel id
BANK_ID, 0, bank index this instance serves
BANK_WIDTH, 2, number of address bits that select the bank
BANK_LSB, 6, lowest address bit of the bank field (byte bits + offset bits)
WBUF_W, 5, write-buffer id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ch_valid_i  in  N_CH  per-channel request valid
ch_ready_o  out  N_CH  per-channel accept; a transfer occurs when valid and ready are both high
ch_op_i  in  3*N_CH  per-channel op (0=LOAD, 1=STORE); channel k uses [3k+2:3k]
ch_addr_i  in  32*N_CH  per-channel byte address
ch_wdata_i  in  128*N_CH  per-channel write data
ch_wbuf_id_i  in  WBUF_W*N_CH  per-channel write-buffer id; meaningful for STORE only
bank_valid_o  out  1  bank request valid
bank_ready_i  in  1  bank accepts the request
bank_req_o  out  N_CH+WBUF_W+3+32+128  packed {channel_1hot_id, wbuffer_id, op, addr, wdata}; 171 bits at defaults
err_illegal_op_o  out  1  one-cycle pulse when an illegal-op request is consumed

Behaviour:
- Reset (async assert, sync deassert): bank_valid_o=0, bank_req_o=0, rr_ptr=0, err_illegal_op_o=0. ch_ready_o is 0 while rst_ni is low.
- Match: match[k] = ch_valid_i[k] & (ch_addr_i[k][BANK_LSB+BANK_WIDTH-1:BANK_LSB] == BANK_ID).
- Non-matching requests get ch_ready_o[k]=0 and are never consumed. Channel-side steering is not this block's job.
- Load enable: ld = !bank_valid_o | bank_ready_i. The output register is a full-throughput single stage.
- Grant: when ld is high, the first matching k scanning rr_ptr, rr_ptr+1, ... mod N_CH is granted.
  - ch_ready_o = onehot(k). This is combinational from the inputs and the registered state; it never depends on ch_ready_o itself.
  - When ld is low, ch_ready_o=0.
- On a grant with a legal op (LOAD or STORE):
  - next cycle bank_valid_o=1.
  - bank_req_o = {onehot(k), wbuf_id[k] for STORE or 0 for LOAD, op[k], addr[k], wdata[k]}.
- On a grant with an illegal op (op>1):
  - the request is consumed (ready=1) and dropped.
  - next cycle err_illegal_op_o=1; bank_valid_o is loaded 0 on that edge.
- rr_ptr update: on any grant, rr_ptr <= (k+1) mod N_CH. Otherwise rr_ptr holds. No grant means no pointer change.
- Backpressure: while bank_valid_o=1 and bank_ready_i=0, bank_req_o and bank_valid_o hold stable and all ch_ready_o are 0.
- Simultaneous bank accept and new grant: the register reloads in the same cycle with no bubble. Sustained throughput is 1 request/cycle.
- If bank_ready_i=1 and there is no match, bank_valid_o <= 0 and bank_req_o holds its last value.
- Latency: 1 cycle from channel handshake to bank_valid_o.
- Fairness: a continuously matching channel is granted within N_CH grants.
- Reset mid-operation: an in-flight bank request is discarded, the pointer returns to 0, and no handshake completes during reset.
- Channel inputs must stay stable while valid and not ready. The block does not check this.

Test Plan:
- Single request: ch0 LOAD addr=0x0000_0000 (bank 0), bank_ready_i=1 -> ch_ready_o=3'b001 at cycle 0; cycle 1 bank_valid_o=1, req id=3'b001, wbuffer_id=0, op=0, addr=0x0.
- Contention: ch0/1/2 all valid and matching, held after each grant, bank_ready_i=1, rr_ptr=0 -> grant order ch0,ch1,ch2,ch0 on consecutive cycles with no bubbles; ids 001,010,100,001.
- Backpressure: ch1 STORE wbuf=5, wdata=0xA5..A5, then bank_ready_i=0 for 4 cycles -> bank_req_o stable with id 010, wbuffer_id=5; ch_ready_o=0 throughout; release -> next request issued the same cycle.
- Bank filter: BANK_ID=0, ch2 addr=0x40 (bank 1) -> ch_ready_o[2]=0 indefinitely and bank_valid_o stays 0; a ch0 request to addr 0x80 (bank 2) is also not accepted.
- Illegal op: ch0 op=3'd4 -> consumed in 1 cycle; err_illegal_op_o pulses once; bank_valid_o stays 0; rr_ptr becomes 1.
- Reset mid-flight: bank_valid_o=1 and stalled, assert rst_ni=0 asynchronously -> outputs clear immediately; after release, ch1 and ch2 valid -> ch1 granted first (rr_ptr=0 so scan 0,1).
